// File: rtl/aer_spike_frame_loader.sv
// AER spike frame loader: gathers address-event spikes into a frame, double-buffers
// closed frames and hands one to the synaptic input processor per flush request.
module aer_spike_frame_loader #(
    parameter int N_SYN  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              aer_valid,
    input  logic [ADDR_W-1:0] aer_addr,
    output logic              aer_ready,
    input  logic              frame_end,
    input  logic              flush_spike,
    output logic [N_SYN-1:0]  parallel_spike_in,
    output logic              frame_pending,
    output logic [CNT_W-1:0]  frame_count,
    output logic              overrun,
    output logic              underrun
);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_CLOSED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_SYN-1:0]   shadow_q, shadow_d;
    logic [N_SYN-1:0]   staged_q, staged_d;
    logic               staged_valid_q, staged_valid_d;
    logic [N_SYN-1:0]   active_q, active_d;
    logic               flush_d_q, flush_d_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic               overrun_q, overrun_d;
    logic               underrun_q, underrun_d;

    logic               accept_s;
    logic               flush_ev_s;
    logic               staged_free_s;
    logic [N_SYN-1:0]   ev_vec_s;

    // Next-state computation for the frame buffers, FSM and status flags.
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        staged_d       = staged_q;
        staged_valid_d = staged_valid_q;
        active_d       = active_q;
        frame_count_d  = frame_count_q;
        overrun_d      = overrun_q;
        underrun_d     = underrun_q;
        flush_d_d      = flush_spike;

        accept_s   = aer_valid && (state_q == ST_OPEN);
        flush_ev_s = flush_spike && !flush_d_q;
        // Out-of-range addresses shift the single set bit off the top and vanish.
        if (accept_s) begin
            ev_vec_s = {{(N_SYN-1){1'b0}}, 1'b1} << aer_addr;
        end else begin
            ev_vec_s = {N_SYN{1'b0}};
        end
        staged_free_s = !staged_valid_q || flush_ev_s;

        if (flush_ev_s) begin
            if (staged_valid_q) begin
                active_d       = staged_q;
                staged_valid_d = 1'b0;
                frame_count_d  = frame_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                active_d   = {N_SYN{1'b0}};
                underrun_d = 1'b1;
            end
        end else begin
            active_d = active_q;
        end

        case (state_q)
            ST_OPEN: begin
                shadow_d = shadow_q | ev_vec_s;
                if (frame_end) begin
                    if (staged_free_s) begin
                        staged_d       = shadow_q | ev_vec_s;
                        staged_valid_d = 1'b1;
                        shadow_d       = {N_SYN{1'b0}};
                    end else begin
                        state_d = ST_CLOSED;
                    end
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_CLOSED: begin
                if (frame_end) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                // The held frame moves up on the same edge that empties staged.
                if (flush_ev_s && staged_valid_q) begin
                    staged_d       = shadow_q;
                    staged_valid_d = 1'b1;
                    shadow_d       = {N_SYN{1'b0}};
                    state_d        = ST_OPEN;
                end else begin
                    state_d = ST_CLOSED;
                end
            end
            default: begin
                state_d = ST_OPEN;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_OPEN;
            shadow_q       <= {N_SYN{1'b0}};
            staged_q       <= {N_SYN{1'b0}};
            staged_valid_q <= 1'b0;
            active_q       <= {N_SYN{1'b0}};
            flush_d_q      <= 1'b0;
            frame_count_q  <= {CNT_W{1'b0}};
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            staged_q       <= staged_d;
            staged_valid_q <= staged_valid_d;
            active_q       <= active_d;
            flush_d_q      <= flush_d_d;
            frame_count_q  <= frame_count_d;
            overrun_q      <= overrun_d;
            underrun_q     <= underrun_d;
        end
    end

    assign aer_ready         = (state_q == ST_OPEN);
    assign parallel_spike_in = active_q;
    assign frame_pending     = staged_valid_q;
    assign frame_count       = frame_count_q;
    assign overrun           = overrun_q;
    assign underrun          = underrun_q;

endmodule

// File: tb/tb_aer_spike_frame_loader.sv
// Directed plus random test of aer_spike_frame_loader against a queue-of-frames model.
module tb_aer_spike_frame_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        aer_valid;
    logic [3:0]  aer_addr;
    logic        aer_ready;
    logic        frame_end;
    logic        flush_spike;
    logic [15:0] parallel_spike_in;
    logic        frame_pending;
    logic [7:0]  frame_count;
    logic        overrun;
    logic        underrun;

    aer_spike_frame_loader #(.N_SYN(16), .ADDR_W(4), .CNT_W(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .aer_valid         (aer_valid),
        .aer_addr          (aer_addr),
        .aer_ready         (aer_ready),
        .frame_end         (frame_end),
        .flush_spike       (flush_spike),
        .parallel_spike_in (parallel_spike_in),
        .frame_pending     (frame_pending),
        .frame_count       (frame_count),
        .overrun           (overrun),
        .underrun          (underrun)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: frame being built plus a FIFO of closed frames awaiting delivery (max 2).
    logic [15:0] m_acc;
    logic [15:0] m_active;
    logic [15:0] m_q[$];
    int          m_cnt;
    bit          m_ovr, m_und, m_flush_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("parallel_spike_in", {16'd0, parallel_spike_in}, {16'd0, m_active});
        chk("frame_pending", {31'd0, frame_pending}, {31'd0, (m_q.size() > 0)});
        chk("aer_ready", {31'd0, aer_ready}, {31'd0, (m_q.size() < 2)});
        chk("frame_count", {24'd0, frame_count}, m_cnt);
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("underrun", {31'd0, underrun}, {31'd0, m_und});
    endtask

    task automatic model_reset();
        m_acc = 16'd0;
        m_active = 16'd0;
        m_q.delete();
        m_cnt = 0;
        m_ovr = 1'b0;
        m_und = 1'b0;
        m_flush_prev = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [3:0] a, input bit fe, input bit fl);
        int s0;
        logic [15:0] ev;
        aer_valid = v;
        aer_addr = a;
        frame_end = fe;
        flush_spike = fl;
        s0 = m_q.size();
        ev = (v && s0 < 2) ? (16'd1 << a) : 16'd0;
        if (fl && !m_flush_prev) begin
            if (s0 > 0) begin
                m_active = m_q.pop_front();
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_active = 16'd0;
                m_und = 1'b1;
            end
        end
        m_flush_prev = fl;
        if (fe) begin
            if (s0 < 2) begin
                m_q.push_back(m_acc | ev);
                m_acc = 16'd0;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            m_acc = m_acc | ev;
        end
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic ev(input int a);
        cycle(1'b1, 4'(a), 1'b0, 1'b0);
    endtask

    task automatic close_frame();
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic flush_pulse();
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        aer_valid = 1'b0;
        aer_addr = 4'd0;
        frame_end = 1'b0;
        flush_spike = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        aer_valid = 1'b0;
        aer_addr = 4'd0;
        frame_end = 1'b0;
        flush_spike = 1'b0;
        model_reset();

        // Odd addresses form 16'hAAAA
        apply_reset();
        for (int i = 1; i < 16; i += 2) ev(i);
        close_frame();
        chk("pending_after_fe", {31'd0, frame_pending}, 32'd1);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("aaaa_out", {16'd0, parallel_spike_in}, 32'h0000AAAA);
        chk("aaaa_count", {24'd0, frame_count}, 32'd1);
        chk("aaaa_pending", {31'd0, frame_pending}, 32'd0);
        idle();

        // Flush with nothing staged
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("silent_out", {16'd0, parallel_spike_in}, 32'd0);
        chk("silent_underrun", {31'd0, underrun}, 32'd1);
        chk("silent_count", {24'd0, frame_count}, 32'd1);
        idle();

        // Two frames without a flush, then overrun
        apply_reset();
        for (int i = 0; i < 4; i++) ev(i);
        close_frame();
        for (int i = 12; i < 16; i++) ev(i);
        close_frame();
        chk("closed_ready", {31'd0, aer_ready}, 32'd0);
        ev(6);
        close_frame();
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("first_000f", {16'd0, parallel_spike_in}, 32'h0000000F);
        chk("reopen_ready", {31'd0, aer_ready}, 32'd1);
        chk("reopen_pending", {31'd0, frame_pending}, 32'd1);
        idle();
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("second_f000", {16'd0, parallel_spike_in}, 32'h0000F000);
        chk("second_count", {24'd0, frame_count}, 32'd2);
        idle();

        // Flush held high for 5 cycles delivers exactly one frame
        ev(1);
        close_frame();
        ev(2);
        close_frame();
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("held_count", {24'd0, frame_count}, 32'd3);
        chk("held_out", {16'd0, parallel_spike_in}, 32'h00000002);
        idle();
        flush_pulse();

        // Event + frame_end + flush on one edge
        for (int i = 4; i < 8; i++) ev(i);
        close_frame();
        ev(8);
        cycle(1'b1, 4'd0, 1'b1, 1'b1);
        chk("same_edge_out", {16'd0, parallel_spike_in}, 32'h000000F0);
        chk("same_edge_pending", {31'd0, frame_pending}, 32'd1);
        idle();
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("same_edge_staged", {16'd0, parallel_spike_in}, 32'h00000101);
        idle();

        // Reset mid-frame with 16'h1234 staged
        ev(2); ev(4); ev(5); ev(9); ev(12);
        close_frame();
        ev(3);
        reset = 1'b1;
        #1;
        chk("rst_out", {16'd0, parallel_spike_in}, 32'd0);
        chk("rst_pending", {31'd0, frame_pending}, 32'd0);
        chk("rst_count", {24'd0, frame_count}, 32'd0);
        chk("rst_ready", {31'd0, aer_ready}, 32'd1);
        apply_reset();
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("post_rst_out", {16'd0, parallel_spike_in}, 32'd0);
        chk("post_rst_underrun", {31'd0, underrun}, 32'd1);
        idle();

        // Delivery counter wrap
        for (int i = 0; i < 255; i++) begin
            ev(i % 16);
            close_frame();
            flush_pulse();
        end
        chk("count_255", {24'd0, frame_count}, 32'd255);
        close_frame();
        flush_pulse();
        chk("count_wrap", {24'd0, frame_count}, 32'd0);

        // Random traffic
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
